cache_arbiter_rr: RTL and testbench

CACHE_ARBITER_RR -- requirements
Module: cache_arbiter_rr

---
 rtl/cache_arbiter_rr_if.sv | 38 +++
 rtl/cache_arbiter_rr.sv | 128 ++++++++++++
 tb/tb_cache_arbiter_rr.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_arbiter_rr_if.sv
// Requester/L2 bundle for cache_arbiter_rr; slave modport is the arbiter view,
// master modport is the requester + L2 model view.
interface cache_arbiter_rr_if #(
  parameter int N_PORTS = 2,
  parameter int S_LINE  = 256
);
  localparam int GW = $clog2(N_PORTS);

  logic [N_PORTS-1:0]        req_read;
  logic [N_PORTS-1:0]        req_write;
  logic [32*N_PORTS-1:0]     req_address;
  logic [S_LINE*N_PORTS-1:0] req_wdata;
  logic [N_PORTS-1:0]        req_resp;
  logic [S_LINE-1:0]         req_rdata;

  logic                      l2_read;
  logic                      l2_write;
  logic [31:0]               l2_address;
  logic [S_LINE-1:0]         l2_wdata;
  logic                      l2_resp;
  logic [S_LINE-1:0]         l2_rdata;

  logic [GW-1:0]             grant;
  logic                      busy;
  logic                      err_timeout;

  modport slave (
    input  req_read, req_write, req_address, req_wdata, l2_resp, l2_rdata,
    output req_resp, req_rdata, l2_read, l2_write, l2_address, l2_wdata,
           grant, busy, err_timeout
  );

  modport master (
    output req_read, req_write, req_address, req_wdata, l2_resp, l2_rdata,
    input  req_resp, req_rdata, l2_read, l2_write, l2_address, l2_wdata,
           grant, busy, err_timeout
  );
endinterface

// File: rtl/cache_arbiter_rr.sv
// Round-robin L1->L2 line arbiter: grant one cycle after request, completes with l2_resp, one DONE cycle.
// Requesters are held off by the single outstanding slot; optional watchdog under CACHE_ARB_TIMEOUT_EN.
module cache_arbiter_rr #(
  parameter int N_PORTS = 2,
  parameter int S_LINE  = 256,
  parameter int TIMEOUT = 1023
) (
  input logic               clk,
  input logic               rst_n,
  cache_arbiter_rr_if.slave bus
);
  localparam int GW = $clog2(N_PORTS);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state_q, state_d;
  logic [GW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [GW-1:0]     grant_q, grant_d;
  logic              wr_q, wr_d;
  logic [31:0]       addr_q, addr_d;
  logic [S_LINE-1:0] wdata_q, wdata_d;
  logic [N_PORTS-1:0] req;
  logic [GW-1:0]     sel;
  logic              found;
  logic              in_busy;

  function automatic logic [GW-1:0] wrap_add(input logic [GW-1:0] base, input int k);
    logic [GW:0] s;
    s = {1'b0, base} + (GW+1)'(k);
    if (s >= (GW+1)'(N_PORTS)) s = s - (GW+1)'(N_PORTS);
    return s[GW-1:0];
  endfunction

  assign req     = bus.req_read | bus.req_write;
  assign in_busy = (state_q == BUSY);

  // First requester at or after rr_ptr, wrapping upward.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    for (int k = 0; k < N_PORTS; k++) begin
      if (!found && req[wrap_add(rr_ptr_q, k)]) begin
        sel   = wrap_add(rr_ptr_q, k);
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    wr_d     = wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;

    bus.busy       = in_busy;
    bus.grant      = grant_q;
    bus.l2_read    = in_busy & ~wr_q;
    bus.l2_write   = in_busy & wr_q;
    bus.l2_address = in_busy ? addr_q : '0;
    bus.l2_wdata   = in_busy ? wdata_q : '0;
    bus.req_rdata  = bus.l2_rdata;
    bus.req_resp   = '0;

    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = BUSY;
          grant_d = sel;
          // Write wins when a port raises both read and write.
          wr_d    = bus.req_write[sel];
          addr_d  = bus.req_address[32*int'(sel) +: 32];
          wdata_d = bus.req_wdata[S_LINE*int'(sel) +: S_LINE];
        end
      end
      BUSY: begin
        if (bus.l2_resp) begin
          bus.req_resp[grant_q] = 1'b1;
          state_d  = DONE;
          rr_ptr_d = wrap_add(grant_q, 1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

`ifdef CACHE_ARB_TIMEOUT_EN
  logic [15:0] to_cnt_q;
  logic        err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_q <= '0;
      err_q    <= 1'b0;
    end else if (state_q == IDLE && found) begin
      to_cnt_q <= '0;
    end else if (in_busy) begin
      if (to_cnt_q != 16'hFFFF) to_cnt_q <= to_cnt_q + 16'd1;
      if (to_cnt_q == 16'(TIMEOUT - 1)) err_q <= 1'b1;
    end
  end

  assign bus.err_timeout = err_q;
`else
  assign bus.err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_cache_arbiter_rr.sv
// Scoreboarded bench for cache_arbiter_rr: a 2-port and a 4-port instance on one clock/reset.
module tb_cache_arbiter_rr;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

`ifdef CACHE_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  cache_arbiter_rr_if #(.N_PORTS(2), .S_LINE(256)) b2();
  cache_arbiter_rr_if #(.N_PORTS(4), .S_LINE(64))  b4();

  cache_arbiter_rr #(.N_PORTS(2), .S_LINE(256), .TIMEOUT(1023)) u2 (.clk(clk), .rst_n(rst_n), .bus(b2));
  cache_arbiter_rr #(.N_PORTS(4), .S_LINE(64),  .TIMEOUT(10))   u4 (.clk(clk), .rst_n(rst_n), .bus(b4));

  typedef struct {
    int           port;
    logic [255:0] rdata;
    logic [31:0]  addr;
    logic         wr;
  } exp_t;

  exp_t sb2[$];
  exp_t sb4[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input int port, input logic [255:0] rd, input logic [31:0] a, input logic wr);
    exp_t e;
    e.port = port; e.rdata = rd; e.addr = a; e.wr = wr;
    return e;
  endfunction

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  // Monitors: every completion pulse must match the oldest expected transaction.
  always @(negedge clk) begin
    if (b4.req_resp != '0) begin
      if (sb4.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb4_unexpected: req_resp=%b with nothing expected", b4.req_resp);
      end else begin
        exp_t e;
        e = sb4.pop_front();
        chk("sb4_onehot", 256'(b4.req_resp), 256'(4'b1 << e.port));
        chk("sb4_grant",  256'(b4.grant), 256'(e.port));
        chk("sb4_rdata",  256'(b4.req_rdata), 256'(e.rdata[63:0]));
        chk("sb4_addr",   256'(b4.l2_address), 256'(e.addr));
        chk("sb4_op",     256'(b4.l2_write), 256'(e.wr));
      end
    end
  end

  always @(negedge clk) begin
    if (b2.req_resp != '0) begin
      if (sb2.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb2_unexpected: req_resp=%b with nothing expected", b2.req_resp);
      end else begin
        exp_t e;
        e = sb2.pop_front();
        chk("sb2_onehot", 256'(b2.req_resp), 256'(2'b1 << e.port));
        chk("sb2_rdata",  b2.req_rdata, e.rdata);
        chk("sb2_addr",   256'(b2.l2_address), 256'(e.addr));
      end
    end
  end

  // Waits for the grant, answers on BUSY cycle d, returns in the DONE cycle.
  task automatic serve4(input int d, input logic [63:0] rd);
    int n;
    n = 0;
    do begin
      next_cyc();
      n++;
    end while (!b4.busy && n < 20);
    chk("serve4_grant", 256'(b4.busy), 256'(1));
    for (int k = 2; k <= d; k++) next_cyc();
    b4.l2_resp  = 1'b1;
    b4.l2_rdata = rd;
    next_cyc();
    b4.l2_resp  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    b2.req_read = '0; b2.req_write = '0; b2.req_address = '0; b2.req_wdata = '0;
    b2.l2_resp = 1'b0; b2.l2_rdata = '0;
    b4.req_read = '0; b4.req_write = '0; b4.req_address = '0; b4.req_wdata = '0;
    b4.l2_resp = 1'b0; b4.l2_rdata = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy4",  256'(b4.busy), 256'(0));
    chk("rst_grant4", 256'(b4.grant), 256'(0));
    chk("rst_rd2",    256'(b2.l2_read), 256'(0));
    chk("rst_err4",   256'(b4.err_timeout), 256'(0));
    rst_n = 1'b1;

    // Single read on the 2-port arbiter, l2_resp on cycle 5.
    next_cyc();
    b2.req_read = 2'b01;
    b2.req_address[31:0] = 32'h100;
    sb2.push_back(mk(0, {4{64'h0123_4567_89AB_CDEF}}, 32'h100, 1'b0));
    @(negedge clk);
    chk("a_c0_read", 256'(b2.l2_read), 256'(0));
    for (int c = 1; c <= 5; c++) begin
      next_cyc();
      if (c == 5) begin
        b2.l2_resp  = 1'b1;
        b2.l2_rdata = {4{64'h0123_4567_89AB_CDEF}};
      end
      @(negedge clk);
      chk("a_read", 256'(b2.l2_read), 256'(1));
      chk("a_addr", 256'(b2.l2_address), 256'(32'h100));
      if (c == 5) chk("a_resp_c5", 256'(b2.req_resp), 256'(2'b01));
    end
    next_cyc();
    b2.req_read = '0;
    @(negedge clk);
    chk("a_done_busy", 256'(b2.busy), 256'(0));
    chk("a_done_read", 256'(b2.l2_read), 256'(0));
    chk("a_done_resp", 256'(b2.req_resp), 256'(0));
    next_cyc();
    b2.l2_resp = 1'b0;

    // Port 1 alone moves rr_ptr to 2; then ports 1 and 3 together -> 3 then 1.
    next_cyc();
    b4.req_read = 4'b0010;
    b4.req_address[63:32] = 32'h1000;
    sb4.push_back(mk(1, 256'hA1, 32'h1000, 1'b0));
    serve4(2, 64'hA1);
    b4.req_read = '0;
    next_cyc();
    b4.req_read = 4'b1010;
    b4.req_address[127:96] = 32'h3300;
    sb4.push_back(mk(3, 256'hB3, 32'h3300, 1'b0));
    sb4.push_back(mk(1, 256'hB1, 32'h1000, 1'b0));
    serve4(1, 64'hB3);
    b4.req_read[3] = 1'b0;
    serve4(1, 64'hB1);
    b4.req_read = '0;

    // Ports 1 and 2 with rr_ptr=2: port 2 (read+write -> write) first, inputs change mid-BUSY.
    next_cyc();
    b4.req_read  = 4'b0110;
    b4.req_write = 4'b0100;
    b4.req_address[95:64]  = 32'h2000;
    b4.req_wdata[191:128]  = 64'hDEAD_BEEF_CAFE_F00D;
    sb4.push_back(mk(2, 256'hC2, 32'h2000, 1'b1));
    sb4.push_back(mk(1, 256'hC1, 32'h1000, 1'b0));
    next_cyc();
    @(negedge clk);
    chk("c_grant", 256'(b4.grant), 256'(2));
    chk("c_write", 256'(b4.l2_write), 256'(1));
    chk("c_read",  256'(b4.l2_read), 256'(0));
    chk("c_wdata", 256'(b4.l2_wdata), 256'(64'hDEAD_BEEF_CAFE_F00D));
    next_cyc();
    b4.req_address[95:64] = 32'h3000;
    b4.req_wdata[191:128] = 64'h1111_2222_3333_4444;
    b4.req_read[2]  = 1'b0;
    b4.req_write[2] = 1'b0;
    @(negedge clk);
    chk("c_wdata_hold", 256'(b4.l2_wdata), 256'(64'hDEAD_BEEF_CAFE_F00D));
    chk("c_addr_hold",  256'(b4.l2_address), 256'(32'h2000));
    chk("c_busy_drop",  256'(b4.busy), 256'(1));
    next_cyc();
    b4.l2_resp  = 1'b1;
    b4.l2_rdata = 64'hC2;
    next_cyc();
    b4.l2_resp  = 1'b0;
    serve4(1, 64'hC1);
    b4.req_read = '0;

    // Asynchronous reset in BUSY, then a stale l2_resp.
    next_cyc();
    b4.req_read = 4'b1000;
    b4.req_address[127:96] = 32'h500;
    next_cyc();
    @(negedge clk);
    chk("e_busy", 256'(b4.busy), 256'(1));
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("e_rst_busy",  256'(b4.busy), 256'(0));
    chk("e_rst_read",  256'(b4.l2_read), 256'(0));
    chk("e_rst_addr",  256'(b4.l2_address), 256'(0));
    chk("e_rst_grant", 256'(b4.grant), 256'(0));
    next_cyc();
    chk("e_no_grant_in_rst", 256'(b4.busy), 256'(0));
    b4.req_read = '0;
    @(negedge clk);
    rst_n = 1'b1;
    next_cyc();
    b4.l2_resp  = 1'b1;
    b4.l2_rdata = 64'hBAD;
    @(negedge clk);
    chk("e_stale_resp", 256'(b4.req_resp), 256'(0));
    next_cyc();
    b4.l2_resp = 1'b0;

    // All four ports requesting continuously: 0,1,2,3,0,1,2,3.
    next_cyc();
    b4.req_read = 4'hF;
    for (int i = 0; i < 4; i++) b4.req_address[32*i +: 32] = 32'h4000 + 32'(i * 16);
    for (int i = 0; i < 8; i++) sb4.push_back(mk(i % 4, 256'(64'hD0 + 64'(i)), 32'h4000 + 32'((i % 4) * 16), 1'b0));
    for (int i = 0; i < 8; i++) serve4(1, 64'hD0 + 64'(i));
    b4.req_read = '0;

    // Watchdog: l2_resp withheld for 12 BUSY cycles, TIMEOUT=10.
    next_cyc();
    b4.req_read = 4'b0001;
    sb4.push_back(mk(0, 256'hF0, 32'h4000, 1'b0));
    next_cyc();
    for (int c = 1; c <= 13; c++) begin
      if (c == 13) begin
        b4.l2_resp  = 1'b1;
        b4.l2_rdata = 64'hF0;
      end
      @(negedge clk);
      chk("f_err", 256'(b4.err_timeout), 256'(TO_EN && c > 10));
      if (c < 13) next_cyc();
    end
    next_cyc();
    b4.l2_resp  = 1'b0;
    b4.req_read = '0;
    @(negedge clk);
    chk("f_done_busy", 256'(b4.busy), 256'(0));
    chk("f_err_done",  256'(b4.err_timeout), 256'(TO_EN));
    repeat (3) next_cyc();
    @(negedge clk);
    chk("f_err_sticky", 256'(b4.err_timeout), 256'(TO_EN));

    chk("sb2_empty", 256'(sb2.size()), 256'(0));
    chk("sb4_empty", 256'(sb4.size()), 256'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
